// File: rtl/mixed_opcode_scheduler_if.sv
// Request/command bundle for mixed_opcode_scheduler.
// The master modport is the scheduler side: it accepts requests and drives the command channel.
// The slave modport is the environment side: the requesters plus the downstream consumer.
interface mixed_opcode_scheduler_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned SRC_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*3-1:0] req_opcode;
  logic [NUM_REQ*6-1:0] req_index;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [8:0]           cmd_tag;
  logic [2:0]           cmd_op;
  logic [SRC_W-1:0]     cmd_src;
  logic                 rd_done;
  logic [3:0]           rd_credits;
  logic                 err_opcode;

  modport master (
    input  req_valid, req_opcode, req_index, cmd_ready, rd_done,
    output req_ready, cmd_valid, cmd_tag, cmd_op, cmd_src, rd_credits, err_opcode
  );

  modport slave (
    output req_valid, req_opcode, req_index, cmd_ready, rd_done,
    input  req_ready, cmd_valid, cmd_tag, cmd_op, cmd_src, rd_credits, err_opcode
  );
endinterface

// File: rtl/mixed_opcode_scheduler.sv
// Round-robin scheduler that maps (opcode, index) requests onto one command channel,
// limits outstanding READs with a credit counter and stalls the channel for WAIT commands.
// Optional per-opcode handshake counters are built when MIXED_OPCODE_SCHED_STATS_EN is defined.
module mixed_opcode_scheduler #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned MAX_RD_OUT = 4,
  parameter int unsigned SRC_W      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MIXED_OPCODE_SCHED_STATS_EN
  input  logic                 stat_clr,
  output logic [5*16-1:0]      stat_cnt,
`endif
  mixed_opcode_scheduler_if.master bus
);

  localparam logic [2:0] OpRead = 3'd0;
  localparam logic [2:0] OpWait = 3'd2;
  localparam logic [2:0] OpTrim = 3'd4;
  localparam logic [3:0] MaxCred = 4'(MAX_RD_OUT);

  typedef enum logic [1:0] {StArb, StSend, StWaitCnt, StErr} state_e;

  state_e           state_q, state_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [2:0]       op_q, op_d;
  logic [5:0]       idx_q, idx_d;
  logic [8:0]       tag_q, tag_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             issued_q, issued_d;
  logic [3:0]       credits_q, credits_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] req_ready;
  logic               grant_vld;
  logic [SRC_W-1:0]   grant_idx;
  logic [2:0]         sel_op;
  logic [5:0]         sel_idx;
  logic               cmd_valid;
  logic               err_opcode;
  logic               hs;

  function automatic logic [8:0] base_of(input logic [2:0] op);
    logic [8:0] base;
    unique case (op)
      3'd0:    base = 9'h000;
      3'd1:    base = 9'h040;
      3'd2:    base = 9'h080;
      3'd3:    base = 9'h0C0;
      3'd4:    base = 9'h100;
      default: base = 9'h000;
    endcase
    return base;
  endfunction

  // A READ is only a candidate while at least one credit is left.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.req_valid[i] &&
                    !((bus.req_opcode[3*i +: 3] == OpRead) && (credits_q == 4'd0));
    end
  end

  // Round-robin pick: first eligible requester at or after the pointer.
  always_comb begin
    logic [SRC_W-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr_q + SRC_W'(k);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    sel_op  = bus.req_opcode[3*grant_idx +: 3];
    sel_idx = bus.req_index[6*grant_idx +: 6];
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    src_d      = src_q;
    op_d       = op_q;
    idx_d      = idx_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    issued_d   = issued_q;
    req_ready  = '0;
    cmd_valid  = 1'b0;
    err_opcode = 1'b0;
    hs         = 1'b0;
    unique case (state_q)
      StArb: begin
        if (grant_vld && rst_n) begin
          req_ready[grant_idx] = 1'b1;
          src_d    = grant_idx;
          op_d     = sel_op;
          idx_d    = sel_idx;
          tag_d    = base_of(sel_op) + {3'b000, sel_idx};
          ptr_d    = grant_idx + SRC_W'(1);
          issued_d = 1'b0;
          if (sel_op == OpWait)     state_d = StWaitCnt;
          else if (sel_op > OpTrim) state_d = StErr;
          else                      state_d = StSend;
        end
      end
      StSend: begin
        cmd_valid = 1'b1;
        if (bus.cmd_ready) begin
          hs      = 1'b1;
          state_d = StArb;
        end
      end
      StWaitCnt: begin
        if (!issued_q) begin
          // WAIT itself goes downstream before the idle countdown starts.
          cmd_valid = 1'b1;
          if (bus.cmd_ready) begin
            hs = 1'b1;
            if (idx_q == 6'd0) begin
              state_d = StArb;
            end else begin
              issued_d = 1'b1;
              cnt_d    = idx_q;
            end
          end
        end else begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = StArb;
        end
      end
      StErr: begin
        err_opcode = 1'b1;
        state_d    = StArb;
      end
      default: state_d = StArb;
    endcase
  end

  // Credit counter: READ handshake consumes, rd_done returns (ignored when none outstanding).
  always_comb begin
    logic rd_hs;
    logic rd_ok;
    rd_hs     = hs && (op_q == OpRead);
    rd_ok     = bus.rd_done && (credits_q != MaxCred);
    credits_d = credits_q;
    if (rd_hs && !rd_ok)      credits_d = credits_q - 4'd1;
    else if (rd_ok && !rd_hs) credits_d = credits_q + 4'd1;
  end

  // State and command registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StArb;
      ptr_q     <= '0;
      src_q     <= '0;
      op_q      <= '0;
      idx_q     <= '0;
      tag_q     <= '0;
      cnt_q     <= '0;
      issued_q  <= 1'b0;
      credits_q <= MaxCred;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      src_q     <= src_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      issued_q  <= issued_d;
      credits_q <= credits_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.cmd_valid  = cmd_valid;
  assign bus.cmd_tag    = tag_q;
  assign bus.cmd_op     = op_q;
  assign bus.cmd_src    = src_q;
  assign bus.rd_credits = credits_q;
  assign bus.err_opcode = err_opcode;

`ifdef MIXED_OPCODE_SCHED_STATS_EN
  logic [15:0] stat_q [5];

  // Saturating per-opcode handshake counters; clear beats increment.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 5; n++) begin
      if (!rst_n || stat_clr) begin
        stat_q[n] <= '0;
      end else if (hs && (op_q == 3'(n)) && (stat_q[n] != 16'hFFFF)) begin
        stat_q[n] <= stat_q[n] + 16'd1;
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    for (int n = 0; n < 5; n++) stat_cnt[16*n +: 16] = stat_q[n];
  end
`endif

endmodule

// File: tb/tb_mixed_opcode_scheduler.sv
// Self-checking bench for mixed_opcode_scheduler: vector table, directed corner sequences
// and a randomized run against a transaction-level reference model.
module tb_mixed_opcode_scheduler;
  localparam int NUM_REQ    = 2;
  localparam int MAX_RD_OUT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mixed_opcode_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef MIXED_OPCODE_SCHED_STATS_EN
  logic        stat_clr = 1'b0;
  logic [79:0] stat_cnt;
`endif

  mixed_opcode_scheduler #(.NUM_REQ(NUM_REQ), .MAX_RD_OUT(MAX_RD_OUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef MIXED_OPCODE_SCHED_STATS_EN
    .stat_clr (stat_clr),
    .stat_cnt (stat_cnt),
`endif
    .bus      (bus)
  );

  typedef struct {
    int         src;
    logic [2:0] op;
    logic [5:0] idx;
    logic [8:0] tag;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] op, input logic [5:0] idx);
    bus.req_valid[i]        = v;
    bus.req_opcode[3*i +: 3] = op;
    bus.req_index[6*i +: 6]  = idx;
  endtask

  task automatic idle_inputs();
    bus.req_valid  = '0;
    bus.req_opcode = '0;
    bus.req_index  = '0;
    bus.cmd_ready  = 1'b0;
    bus.rd_done    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model state.
  int         m_out, m_last, m_wait, m_g, p_src;
  bit         m_pend, m_err, m_hs;
  logic [2:0] p_op;
  logic [5:0] p_idx;
  logic [2:0] r_op  [NUM_REQ];
  logic [5:0] r_idx [NUM_REQ];
  logic       r_v   [NUM_REQ];

  vec_t vecs[6];

  initial begin
    idle_inputs();
    do_reset();

    // Reset state.
    #1;
    chk("rst_cmd_valid", 32'(bus.cmd_valid), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_credits", 32'(bus.rd_credits), MAX_RD_OUT);
    chk("rst_err", 32'(bus.err_opcode), 0);
    chk("rst_tag", 32'(bus.cmd_tag), 0);
    chk("rst_op", 32'(bus.cmd_op), 0);
    chk("rst_src", 32'(bus.cmd_src), 0);
    tick();

    // Single-request vectors: tag = base(op) + index.
    vecs[0] = '{0, 3'd1, 6'd5,  9'h045};
    vecs[1] = '{1, 3'd0, 6'd0,  9'h000};
    vecs[2] = '{0, 3'd0, 6'd63, 9'h03F};
    vecs[3] = '{1, 3'd3, 6'd2,  9'h0C2};
    vecs[4] = '{0, 3'd4, 6'd63, 9'h13F};
    vecs[5] = '{1, 3'd2, 6'd0,  9'h080};
    for (int v = 0; v < 6; v++) begin
      idle_inputs();
      bus.cmd_ready = 1'b1;
      set_req(vecs[v].src, 1'b1, vecs[v].op, vecs[v].idx);
      #1;
      chk("vec_ready", 32'(bus.req_ready), 32'(1 << vecs[v].src));
      tick();
      set_req(vecs[v].src, 1'b0, 3'd0, 6'd0);
      #1;
      chk("vec_valid", 32'(bus.cmd_valid), 1);
      chk("vec_tag", 32'(bus.cmd_tag), 32'(vecs[v].tag));
      chk("vec_op", 32'(bus.cmd_op), 32'(vecs[v].op));
      chk("vec_src", 32'(bus.cmd_src), 32'(vecs[v].src));
      tick();
      #1;
      chk("vec_idle", 32'(bus.cmd_valid), 0);
      chk("vec_noready", 32'(bus.req_ready), 0);
      if (vecs[v].op == 3'd0) begin
        chk("vec_rd_credit", 32'(bus.rd_credits), MAX_RD_OUT - 1);
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        #1;
        chk("vec_rd_return", 32'(bus.rd_credits), MAX_RD_OUT);
      end
    end

    // Round-robin alternation with both requesters streaming TRIM 0x3F.
    do_reset();
    bus.cmd_ready = 1'b1;
    set_req(0, 1'b1, 3'd4, 6'd63);
    set_req(1, 1'b1, 3'd4, 6'd63);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 2)));
      tick();
      #1;
      chk("rr_valid", 32'(bus.cmd_valid), 1);
      chk("rr_tag", 32'(bus.cmd_tag), 32'h13F);
      chk("rr_src", 32'(bus.cmd_src), 32'(k % 2));
      tick();
    end

    // Credit exhaustion: four READs issue, fifth is held, EVICT still passes.
    do_reset();
    bus.cmd_ready = 1'b1;
    set_req(0, 1'b1, 3'd0, 6'd7);
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("cr_grant", 32'(bus.req_ready), 1);
      tick();
      #1;
      chk("cr_op", 32'(bus.cmd_op), 0);
      tick();
    end
    #1;
    chk("cr_zero", 32'(bus.rd_credits), 0);
    chk("cr_blocked", 32'(bus.req_ready), 0);
    tick();
    set_req(1, 1'b1, 3'd3, 6'd2);
    #1;
    chk("cr_evict_grant", 32'(bus.req_ready), 2);
    tick();
    set_req(1, 1'b0, 3'd0, 6'd0);
    #1;
    chk("cr_evict_tag", 32'(bus.cmd_tag), 32'h0C2);
    chk("cr_evict_src", 32'(bus.cmd_src), 1);
    tick();
    #1;
    chk("cr_still_blocked", 32'(bus.req_ready), 0);
    bus.rd_done = 1'b1;
    tick();
    bus.rd_done = 1'b0;
    #1;
    chk("cr_one_back", 32'(bus.rd_credits), 1);
    chk("cr_fifth_grant", 32'(bus.req_ready), 1);
    tick();
    set_req(0, 1'b0, 3'd0, 6'd0);
    #1;
    chk("cr_fifth_valid", 32'(bus.cmd_valid), 1);
    tick();
    #1;
    chk("cr_zero_again", 32'(bus.rd_credits), 0);

    // WAIT 3: command issued, then three idle cycles, then req0 wins.
    do_reset();
    bus.cmd_ready = 1'b1;
    set_req(1, 1'b1, 3'd2, 6'd3);
    #1;
    chk("wt_grant", 32'(bus.req_ready), 2);
    tick();
    set_req(1, 1'b0, 3'd0, 6'd0);
    set_req(0, 1'b1, 3'd1, 6'd9);
    #1;
    chk("wt_valid", 32'(bus.cmd_valid), 1);
    chk("wt_tag", 32'(bus.cmd_tag), 32'h083);
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("wt_idle_valid", 32'(bus.cmd_valid), 0);
      chk("wt_idle_ready", 32'(bus.req_ready), 0);
      tick();
    end
    #1;
    chk("wt_after", 32'(bus.req_ready), 1);

    // Illegal opcode: error pulse, nothing issued, next grant goes to req1.
    do_reset();
    set_req(0, 1'b1, 3'd6, 6'd0);
    #1;
    chk("er_grant", 32'(bus.req_ready), 1);
    tick();
    set_req(0, 1'b1, 3'd1, 6'd1);
    set_req(1, 1'b1, 3'd1, 6'd2);
    bus.cmd_ready = 1'b1;
    #1;
    chk("er_pulse", 32'(bus.err_opcode), 1);
    chk("er_no_cmd", 32'(bus.cmd_valid), 0);
    chk("er_no_ready", 32'(bus.req_ready), 0);
    tick();
    #1;
    chk("er_pulse_end", 32'(bus.err_opcode), 0);
    chk("er_next_grant", 32'(bus.req_ready), 2);

    // Reset while a command is stalled in SEND.
    do_reset();
    bus.cmd_ready = 1'b1;
    set_req(0, 1'b1, 3'd0, 6'd0);
    #1;
    chk("rs_read_grant", 32'(bus.req_ready), 1);
    tick();
    set_req(0, 1'b0, 3'd0, 6'd0);
    tick();
    bus.cmd_ready = 1'b0;
    set_req(0, 1'b1, 3'd1, 6'd4);
    #1;
    chk("rs_credits_used", 32'(bus.rd_credits), MAX_RD_OUT - 1);
    chk("rs_write_grant", 32'(bus.req_ready), 1);
    tick();
    set_req(0, 1'b0, 3'd0, 6'd0);
    tick();
    #1;
    chk("rs_stalled", 32'(bus.cmd_valid), 1);
    chk("rs_stable_tag", 32'(bus.cmd_tag), 32'h044);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_req(0, 1'b1, 3'd1, 6'd1);
    set_req(1, 1'b1, 3'd1, 6'd1);
    #1;
    chk("rs_valid", 32'(bus.cmd_valid), 0);
    chk("rs_credits", 32'(bus.rd_credits), MAX_RD_OUT);
    chk("rs_ptr", 32'(bus.req_ready), 1);

    // Randomized run against the reference model.
    do_reset();
    m_out = 0; m_last = NUM_REQ - 1; m_wait = 0; m_pend = 0; m_err = 0;
    p_op = '0; p_idx = '0; p_src = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        int r;
        r       = int'($urandom_range(0, 16));
        r_v[i]  = ($urandom_range(0, 2) != 0);
        r_op[i] = (r < 14) ? 3'(r % 5) : 3'(r - 9);
        r_idx[i] = (r_op[i] == 3'd2) ? 6'($urandom_range(0, 4)) : 6'($urandom_range(0, 63));
        set_req(i, r_v[i], r_op[i], r_idx[i]);
      end
      bus.cmd_ready = ($urandom_range(0, 3) != 0);
      bus.rd_done   = ($urandom_range(0, 3) == 0);
      #1;
      m_g = -1;
      if (!m_pend && m_wait == 0 && !m_err) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          int c;
          c = (m_last + 1 + k) % NUM_REQ;
          if (m_g < 0 && r_v[c] && !(r_op[c] == 3'd0 && m_out == MAX_RD_OUT)) m_g = c;
        end
      end
      chk("rnd_ready", 32'(bus.req_ready), (m_g >= 0) ? 32'(1 << m_g) : 0);
      chk("rnd_valid", 32'(bus.cmd_valid), 32'(m_pend));
      chk("rnd_err", 32'(bus.err_opcode), 32'(m_err));
      chk("rnd_credits", 32'(bus.rd_credits), MAX_RD_OUT - m_out);
      if (m_pend) begin
        chk("rnd_tag", 32'(bus.cmd_tag), 32'(p_op) * 64 + 32'(p_idx));
        chk("rnd_op", 32'(bus.cmd_op), 32'(p_op));
        chk("rnd_src", 32'(bus.cmd_src), 32'(p_src));
      end
      m_hs = m_pend && bus.cmd_ready;
      if (bus.rd_done && m_out > 0) m_out--;
      if (m_hs && p_op == 3'd0) m_out++;
      if (m_err) begin
        m_err = 0;
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (m_pend) begin
        if (m_hs) begin
          m_pend = 0;
          if (p_op == 3'd2) m_wait = int'(p_idx);
        end
      end else if (m_g >= 0) begin
        m_last = m_g;
        if (r_op[m_g] > 3'd4) begin
          m_err = 1;
        end else begin
          m_pend = 1;
          p_op   = r_op[m_g];
          p_idx  = r_idx[m_g];
          p_src  = m_g;
        end
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
